// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for the 3-digit BCD counter: debounced buttons, tick pacing, target stop.
// Define AUTO_RELOAD_EN to restart counting on a target match instead of stopping in DONE.
module bcd_count_ctrl #(
  parameter int DEB_CYCLES = 20000,
  parameter int TICK_DIV   = 100000
) (
  input  logic       clk_1MHz,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       btn_lap,
  input  logic [3:0] cnt_u,
  input  logic [3:0] cnt_t,
  input  logic [3:0] cnt_h,
  input  logic [3:0] tgt_u,
  input  logic [3:0] tgt_t,
  input  logic [3:0] tgt_h,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_freeze,
  output logic       done,
  output logic [1:0] state
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int PRE_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  logic [2:0] btn_raw;
  logic [2:0] press;
  logic       press_run;
  logic       press_clr;
  logic       press_lap;

  assign btn_raw   = {btn_lap, btn_clr, btn_run};
  assign press_run = press[0];
  assign press_clr = press[1];
  assign press_lap = press[2];

  // Synchronizer, stability counter and rising-edge detect per button
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic             deb_prev_reg;
    logic [DEB_W-1:0] deb_cnt_reg;

    always_ff @(posedge clk_1MHz) begin
      if (reset) begin
        sync1_reg    <= 1'b0;
        sync2_reg    <= 1'b0;
        deb_reg      <= 1'b0;
        deb_prev_reg <= 1'b0;
        deb_cnt_reg  <= '0;
      end else begin
        sync1_reg    <= btn_raw[gi];
        sync2_reg    <= sync1_reg;
        deb_prev_reg <= deb_reg;
        if (sync2_reg == deb_reg) begin
          deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
          deb_reg     <= sync2_reg;
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end
    end

    assign press[gi] = deb_reg & ~deb_prev_reg;
  end

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] presc_reg, presc_next;
  logic             freeze_reg, freeze_next;
  logic             clr_reg, clr_next;
  logic             en_reg, en_next;
  logic             done_reg, done_next;
  logic             tgt_valid;
  logic             match;
  logic             presc_last;

  assign tgt_valid  = ({tgt_h, tgt_t, tgt_u} != 12'h000) &&
                      (tgt_h <= 4'd9) && (tgt_t <= 4'd9) && (tgt_u <= 4'd9);
  // The counter clears on the edge after a cnt_clr strobe, so its value is stale for that cycle
  assign match      = tgt_valid && !clr_reg &&
                      ({cnt_h, cnt_t, cnt_u} == {tgt_h, tgt_t, tgt_u});
  assign presc_last = (presc_reg == PRE_W'(TICK_DIV - 1));

  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    freeze_next = freeze_reg;
    clr_next    = 1'b0;
    en_next     = 1'b0;
    done_next   = 1'b0;
    if (press_clr) begin
      state_next  = S_IDLE;
      clr_next    = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE:  if (press_run) state_next = S_RUN;
        S_RUN: begin
          if (match) begin
`ifdef AUTO_RELOAD_EN
            clr_next   = 1'b1;
            presc_next = '0;
            done_next  = 1'b1;
`else
            state_next = S_DONE;
`endif
          end else if (press_run) begin
            // Prescaler holds on the pause edge so resuming keeps the remaining count
            state_next = S_PAUSE;
          end else begin
            presc_next = presc_last ? '0 : presc_reg + 1'b1;
            en_next    = presc_last;
          end
        end
        S_PAUSE: if (press_run) state_next = S_RUN;
        S_DONE: begin
          if (press_run) begin
            state_next = S_IDLE;
            clr_next   = 1'b1;
          end
        end
      endcase
      if (press_lap && (state_reg == S_RUN || state_reg == S_PAUSE))
        freeze_next = ~freeze_reg;
    end
    if (state_next == S_IDLE || state_next == S_DONE) begin
      presc_next = '0;
    end
    if (state_next == S_IDLE) begin
      freeze_next = 1'b0;
    end
`ifndef AUTO_RELOAD_EN
    done_next = (state_next == S_DONE);
`endif
  end

  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      presc_reg  <= '0;
      freeze_reg <= 1'b0;
      clr_reg    <= 1'b0;
      en_reg     <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      freeze_reg <= freeze_next;
      clr_reg    <= clr_next;
      en_reg     <= en_next;
      done_reg   <= done_next;
    end
  end

  assign cnt_en      = en_reg;
  assign cnt_clr     = clr_reg;
  assign disp_freeze = freeze_reg;
  assign done        = done_reg;
  assign state       = state_reg;

endmodule
